// File: rtl/ibex_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// The source enum tags every outstanding transaction so its response can be routed back.
package ibex_mem_arbiter_pkg;

  typedef enum logic {
    MemSrcInstr = 1'b0,
    MemSrcData  = 1'b1
  } mem_src_e;

  localparam logic [3:0] InstrBe        = 4'hF;
  localparam logic [31:0] InstrWdata    = 32'h0000_0000;
  localparam logic [6:0]  InstrWdataIntg = 7'h00;

  function automatic mem_src_e other_src(input mem_src_e src);
    mem_src_e result;
    case (src)
      MemSrcInstr: result = MemSrcData;
      MemSrcData:  result = MemSrcInstr;
      default:     result = MemSrcInstr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ibex_mem_arb_txn_fifo.sv
// In-order tracker of granted-but-unanswered transactions.
// Each entry records which source issued the request so the response can be steered back.
module ibex_mem_arb_txn_fifo
  import ibex_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  mem_src_e push_id,
  input  logic     pop,
  output mem_src_e head_id,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  mem_src_e        entries_r [Depth];
  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            push_en_s;
  logic            pop_en_s;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] result;
    if (ptr == LastPtr) begin
      result = '0;
    end else begin
      result = ptr + PtrW'(1);
    end
    return result;
  endfunction

  assign full      = (count_r == DepthCnt);
  assign empty     = (count_r == CntW'(0));
  assign push_en_s = push & ~full;
  assign pop_en_s  = pop & ~empty;
  assign head_id   = entries_r[rd_ptr_r];

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        entries_r[i] <= MemSrcInstr;
      end
    end else if (push_en_s) begin
      entries_r[wr_ptr_r] <= push_id;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_en_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Two-to-one arbiter sharing one req/gnt/rvalid memory port between fetch and LSU.
// Round-robin on ties, locked selection while a request waits, in-order response routing.
module ibex_mem_arbiter
  import ibex_mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i,

  output logic        rsp_unexpected_o
);

  mem_src_e sel_src_s;
  logic     sel_req_s;
  logic     grant_s;
  logic     pop_s;
  logic     lock_r;
  mem_src_e lock_src_r;
  mem_src_e last_src_r;
  logic     unexpected_r;
  mem_src_e head_id_s;
  logic     full_s;
  logic     empty_s;

  // Source selection: a waiting request keeps the bus, otherwise round-robin on ties.
  always_comb begin
    sel_src_s = MemSrcInstr;
    if (lock_r) begin
      sel_src_s = lock_src_r;
    end else if (instr_req_i && data_req_i) begin
      sel_src_s = other_src(last_src_r);
    end else if (data_req_i) begin
      sel_src_s = MemSrcData;
    end else begin
      sel_src_s = MemSrcInstr;
    end
  end

  // Downstream request mux; fetches are always full-word reads.
  always_comb begin
    sel_req_s        = 1'b0;
    mem_we_o         = 1'b0;
    mem_be_o         = InstrBe;
    mem_addr_o       = instr_addr_i;
    mem_wdata_o      = InstrWdata;
    mem_wdata_intg_o = InstrWdataIntg;
    case (sel_src_s)
      MemSrcInstr: begin
        sel_req_s = instr_req_i;
      end
      MemSrcData: begin
        sel_req_s        = data_req_i;
        mem_we_o         = data_we_i;
        mem_be_o         = data_be_i;
        mem_addr_o       = data_addr_i;
        mem_wdata_o      = data_wdata_i;
        mem_wdata_intg_o = data_wdata_intg_i;
      end
      default: begin
        sel_req_s = 1'b0;
      end
    endcase
  end

  // A full tracker blocks new requests; a same-cycle pop does not count as space.
  assign mem_req_o = sel_req_s & ~full_s;
  assign grant_s   = mem_req_o & mem_gnt_i;
  assign pop_s     = mem_rvalid_i & ~empty_s;

  // Grant and response steering, combinational from the memory handshake.
  always_comb begin
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    if (sel_src_s == MemSrcData) begin
      data_gnt_o = grant_s;
    end else begin
      instr_gnt_o = grant_s;
    end
    if (head_id_s == MemSrcData) begin
      data_rvalid_o = pop_s;
    end else begin
      instr_rvalid_o = pop_s;
    end
  end

  assign instr_rdata_o      = mem_rdata_i;
  assign instr_rdata_intg_o = mem_rdata_intg_i;
  assign instr_err_o        = mem_err_i;
  assign data_rdata_o       = mem_rdata_i;
  assign data_rdata_intg_o  = mem_rdata_intg_i;
  assign data_err_o         = mem_err_i;
  assign rsp_unexpected_o   = unexpected_r;

  // Lock holds the selection while a presented request is not yet granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r     <= 1'b0;
      lock_src_r <= MemSrcInstr;
      last_src_r <= MemSrcInstr;
    end else if (grant_s) begin
      lock_r     <= 1'b0;
      last_src_r <= sel_src_s;
    end else if (mem_req_o) begin
      lock_r     <= 1'b1;
      lock_src_r <= sel_src_s;
    end
  end

  // Sticky flag for a response that has no outstanding transaction to belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexpected_r <= 1'b0;
    end else if (mem_rvalid_i && empty_s) begin
      unexpected_r <= 1'b1;
    end
  end

  ibex_mem_arb_txn_fifo #(
    .Depth (MaxOutstanding)
  ) u_txn_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (grant_s),
    .push_id (sel_src_s),
    .pop     (pop_s),
    .head_id (head_id_s),
    .full    (full_s),
    .empty   (empty_s)
  );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_ibex_mem_arbiter;

  localparam int MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [6:0]  mem_wdata_intg_o, mem_rdata_intg_i;
  logic        rsp_unexpected_o;

  always #5 clk = ~clk;

  ibex_mem_arbiter #(.MaxOutstanding(MaxOut)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i),
    .mem_err_i(mem_err_i), .rsp_unexpected_o(rsp_unexpected_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ids of outstanding transactions (0 = instr, 1 = data).
  bit q[$];
  bit owed;        // a request was presented but not granted: it owns the bus next
  bit owed_src;
  bit last_src;
  bit unexp;
  bit g_instr, g_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0;
    data_wdata_i = 32'h0; data_wdata_intg_i = 7'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    mem_rdata_intg_i = 7'h0; mem_err_i = 1'b0;
  endtask

  // Compare DUT against the model in the low phase, then advance the model.
  task automatic eval();
    bit sel, sreq, ereq, g, pop;
    @(negedge clk);
    #1;
    if (owed) sel = owed_src;
    else if (instr_req_i && data_req_i) sel = !last_src;
    else sel = data_req_i;
    sreq = sel ? data_req_i : instr_req_i;
    ereq = sreq && (q.size() < MaxOut);
    g    = ereq && mem_gnt_i;
    pop  = mem_rvalid_i && (q.size() > 0);
    chk("mem_req", mem_req_o, ereq);
    chk("instr_gnt", instr_gnt_o, g && !sel);
    chk("data_gnt", data_gnt_o, g && sel);
    if (ereq) begin
      chk("mem_addr", mem_addr_o, sel ? data_addr_i : instr_addr_i);
      chk("mem_we", mem_we_o, sel ? data_we_i : 1'b0);
      chk("mem_be", mem_be_o, sel ? data_be_i : 4'hF);
      chk("mem_wdata", mem_wdata_o, sel ? data_wdata_i : 32'h0);
      chk("mem_wintg", mem_wdata_intg_o, sel ? data_wdata_intg_i : 7'h0);
    end
    chk("instr_rvalid", instr_rvalid_o, pop && (q[0] == 1'b0));
    chk("data_rvalid", data_rvalid_o, pop && (q[0] == 1'b1));
    chk("instr_rdata", instr_rdata_o, mem_rdata_i);
    chk("data_rdata", data_rdata_o, mem_rdata_i);
    chk("rdata_intg", {data_rdata_intg_o, instr_rdata_intg_o}, {mem_rdata_intg_i, mem_rdata_intg_i});
    chk("err", {data_err_o, instr_err_o}, {mem_err_i, mem_err_i});
    chk("rsp_unexpected", rsp_unexpected_o, unexp);
    if (mem_rvalid_i && q.size() == 0) unexp = 1'b1;
    if (pop) void'(q.pop_front());
    if (g) begin
      q.push_back(sel);
      last_src = sel;
      owed = 1'b0;
    end else if (ereq) begin
      owed = 1'b1;
      owed_src = sel;
    end
    g_instr = g && !sel;
    g_data  = g && sel;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_idle();
    mem_rdata_i = 32'hCAFE0001;
    q.delete();
    owed = 1'b0; owed_src = 1'b0; last_src = 1'b0; unexp = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
    chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    chk("rst_unexpected", rsp_unexpected_o, 1'b0);
    chk("rst_rdata_follow", instr_rdata_o, 32'hCAFE0001);
    adv();
    rst_ni = 1'b1;
    mem_rdata_i = 32'h0;
  endtask

  bit ir_hold, dr_hold;

  initial begin
    rst_ni = 1'b0;
    set_idle();
    adv();
    do_reset();

    // Single data write, response next cycle.
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h100;
    data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1'b1;
    eval();
    chk("single_gnt", data_gnt_o, 1'b1);
    chk("single_addr", mem_addr_o, 32'h100);
    chk("single_be_we", {mem_be_o, mem_we_o}, 5'b0011_1);
    chk("single_wdata", mem_wdata_o, 32'hDEADBEEF);
    adv();
    set_idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A0000;
    eval();
    chk("single_rsp", {data_rvalid_o, instr_rvalid_o}, 2'b10);
    adv();

    // Tie after reset: data, instr, data, instr.
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h40; data_req_i = 1'b1; data_addr_i = 32'h80;
    data_be_i = 4'hF; mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = (i != 0);
      eval();
      chk("tie_order", {instr_gnt_o, data_gnt_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
      adv();
    end
    set_idle(); mem_rvalid_i = 1'b1;
    eval(); adv();

    // Lock: instr waits three cycles while data also requests.
    set_idle(); instr_req_i = 1'b1; instr_addr_i = 32'hA0;
    data_addr_i = 32'h200; data_be_i = 4'h1;
    for (int i = 0; i < 3; i++) begin
      data_req_i = (i != 0);
      eval();
      chk("lock_addr", mem_addr_o, 32'hA0);
      chk("lock_nognt", {instr_gnt_o, data_gnt_o}, 2'b00);
      adv();
    end
    mem_gnt_i = 1'b1;
    eval();
    chk("lock_instr_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    adv();
    eval();
    chk("lock_data_next", {instr_gnt_o, data_gnt_o}, 2'b01);
    adv();

    // Backpressure: tracker full (instr, data outstanding).
    eval();
    chk("full_block", mem_req_o, 1'b0);
    adv();
    mem_rvalid_i = 1'b1;
    eval();
    chk("full_pop_block", mem_req_o, 1'b0);
    chk("route_first_instr", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    adv();
    mem_rvalid_i = 1'b0; data_req_i = 1'b0;
    eval();
    chk("full_relieved", {mem_req_o, instr_gnt_o}, 2'b11);
    adv();

    // Routing: data response with error, then instr.
    set_idle(); mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    eval();
    chk("route_data_err", {data_rvalid_o, data_err_o, instr_rvalid_o}, 3'b110);
    adv();
    mem_err_i = 1'b0;
    eval();
    chk("route_instr", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    adv();

    // Unexpected response with an empty tracker.
    eval();
    chk("unexp_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    adv();
    set_idle();
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("unexp_sticky", rsp_unexpected_o, 1'b1);
      adv();
    end

    // Reset taken with a transaction in flight.
    do_reset();
    data_req_i = 1'b1; data_addr_i = 32'h300; mem_gnt_i = 1'b1;
    eval(); adv();
    do_reset();
    mem_rvalid_i = 1'b1;
    eval();
    chk("stale_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    adv();
    set_idle();
    eval();
    chk("stale_unexpected", rsp_unexpected_o, 1'b1);
    adv();

    // Randomized soak; requesters hold req and attributes until granted.
    do_reset();
    ir_hold = 1'b0; dr_hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir_hold) begin
        instr_req_i = ($urandom_range(0, 99) < 60);
        instr_addr_i = $urandom;
      end
      if (!dr_hold) begin
        data_req_i = ($urandom_range(0, 99) < 60);
        data_we_i = $urandom_range(0, 1);
        data_be_i = 4'($urandom_range(0, 15));
        data_addr_i = $urandom;
        data_wdata_i = $urandom;
        data_wdata_intg_i = 7'($urandom_range(0, 127));
      end
      mem_gnt_i = ($urandom_range(0, 99) < 70);
      mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 99) < 50);
      mem_rdata_i = $urandom;
      mem_rdata_intg_i = 7'($urandom_range(0, 127));
      mem_err_i = $urandom_range(0, 1);
      eval();
      ir_hold = instr_req_i && !g_instr;
      dr_hold = data_req_i && !g_data;
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
